// File: rtl/taxi_led_pwm.sv
// taxi_led_pwm: multi-channel LED PWM dimmer; duty vectors are double-buffered and applied only at
// PWM period boundaries. Define TAXI_LED_PWM_GAMMA_EN for square-law duty mapping at load time.
module taxi_led_pwm #(
    parameter int CHANNELS = 12,
    parameter int DUTY_W   = 8,
    parameter int PRESCALE = 488
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS*DUTY_W-1:0]   duty_in,
    input  logic                         duty_valid,
    output logic                         duty_ready,
    output logic [CHANNELS-1:0]          pwm_out,
    output logic                         period_start
);

    localparam int                PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(PRESCALE - 1);
    localparam logic [DUTY_W-1:0] DUTY_MAX = '1;

    logic [PRE_W-1:0]                pre_q, pre_d;
    logic [DUTY_W-1:0]               cnt_q, cnt_d;
    logic [CHANNELS-1:0][DUTY_W-1:0] shadow_q, shadow_d;
    logic [CHANNELS-1:0][DUTY_W-1:0] active_q, active_d;
    logic                            pending_q, pending_d;
    logic                            ready_q, ready_d;
    logic                            period_start_q, period_start_d;
    logic [CHANNELS-1:0]             pwm_q, pwm_d;
    logic                            step_tick, boundary, accept;

    // Duty mapping applied once per channel when the shadow vector is loaded into active.
    function automatic logic [DUTY_W-1:0] map_duty(input logic [DUTY_W-1:0] d);
`ifdef TAXI_LED_PWM_GAMMA_EN
        logic [2*DUTY_W-1:0] sq;
        sq = {{DUTY_W{1'b0}}, d} * {{DUTY_W{1'b0}}, d};
        if (d == DUTY_MAX) begin
            map_duty = DUTY_MAX;
        end else begin
            map_duty = sq[2*DUTY_W-1:DUTY_W];
        end
`else
        map_duty = d;
`endif
    endfunction

    always_comb begin
        step_tick      = (pre_q == PRE_MAX);
        pre_d          = step_tick ? '0 : pre_q + 1'b1;
        cnt_d          = step_tick ? cnt_q + 1'b1 : cnt_q;
        boundary       = step_tick && (cnt_q == DUTY_MAX);
        accept         = duty_valid && ready_q;
        shadow_d       = shadow_q;
        active_d       = active_q;
        pending_d      = pending_q;
        period_start_d = boundary;

        if (boundary && pending_q) begin
            for (int i = 0; i < CHANNELS; i++) begin
                active_d[i] = map_duty(shadow_q[i]);
            end
            pending_d = 1'b0;
        end

        // An accept on a boundary with nothing pending only fills the shadow; it loads next period.
        if (accept) begin
            shadow_d  = duty_in;
            pending_d = 1'b1;
        end

        ready_d = !pending_d;

        for (int i = 0; i < CHANNELS; i++) begin
            if (active_q[i] == '0) begin
                pwm_d[i] = 1'b0;
            end else if (active_q[i] == DUTY_MAX) begin
                pwm_d[i] = 1'b1;
            end else begin
                pwm_d[i] = (cnt_q < active_q[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q          <= '0;
            cnt_q          <= '0;
            shadow_q       <= '0;
            active_q       <= '0;
            pending_q      <= 1'b0;
            ready_q        <= 1'b0;
            period_start_q <= 1'b0;
            pwm_q          <= '0;
        end else begin
            pre_q          <= pre_d;
            cnt_q          <= cnt_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            ready_q        <= ready_d;
            period_start_q <= period_start_d;
            pwm_q          <= pwm_d;
        end
    end

    assign duty_ready   = ready_q;
    assign pwm_out      = pwm_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_taxi_led_pwm.sv
// Directed self-checking bench for taxi_led_pwm with CHANNELS=4, DUTY_W=4, PRESCALE=2 (32-clk period).
module tb_taxi_led_pwm;

    logic        clk;
    logic        rst;
    logic [15:0] duty_in;
    logic        duty_valid;
    logic        duty_ready;
    logic [3:0]  pwm_out;
    logic        period_start;

    int tests = 0;
    int fails = 0;

    int         hi_cnt [4];
    logic [3:0] first_out;
    int         ps_at;

    localparam logic [15:0] VEC_LIN  = {4'd12, 4'd3, 4'd1, 4'd8};
    localparam logic [15:0] VEC_EXT  = {4'd15, 4'd0, 4'd14, 4'd5};
    localparam logic [15:0] VEC_A    = {4'd10, 4'd6, 4'd2, 4'd4};
    localparam logic [15:0] VEC_B    = {4'd7, 4'd15, 4'd0, 4'd12};
    localparam logic [15:0] VEC_C    = {4'd0, 4'd15, 4'd9, 4'd1};
    localparam logic [15:0] VEC_GAM  = {4'd12, 4'd4, 4'd15, 4'd8};
    localparam logic [15:0] VEC_MID  = {4'd0, 4'd0, 4'd0, 4'd8};
    localparam logic [15:0] VEC_PEND = {4'd15, 4'd15, 4'd15, 4'd15};

    taxi_led_pwm #(
        .CHANNELS(4),
        .DUTY_W  (4),
        .PRESCALE(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .duty_in     (duty_in),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .pwm_out     (pwm_out),
        .period_start(period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected high clocks per 32-clk period for a written duty value.
    function automatic int exp_high(input logic [3:0] d);
        logic [3:0] m;
`ifdef TAXI_LED_PWM_GAMMA_EN
        logic [7:0] sq;
        sq = {4'd0, d} * {4'd0, d};
        m  = (d == 4'd15) ? 4'd15 : sq[7:4];
`else
        m = d;
`endif
        if (m == 4'd0) return 0;
        if (m == 4'd15) return 32;
        return 2 * int'(m);
    endfunction

    function automatic logic [3:0] exp_first(input logic [15:0] v);
        logic [3:0] r;
        for (int c = 0; c < 4; c++) r[c] = (exp_high(v[c*4 +: 4]) > 0);
        return r;
    endfunction

    task automatic wait_ps(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = period_start;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("[TB] FAIL %s: period_start timeout, got 0 want 1", tag);
        end
    endtask

    // Called on a negedge; holds valid until the DUT takes the vector.
    task automatic send_vec(input logic [15:0] v, input string tag);
        bit done;
        done       = 1'b0;
        duty_in    = v;
        duty_valid = 1'b1;
        for (int k = 0; k < 80 && !done; k++) begin
            if (duty_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        duty_valid = 1'b0;
        tests++;
        if (!done) begin
            fails++;
            $display("[TB] FAIL %s: accept timeout, got 0 want 1", tag);
        end
    endtask

    // Samples the 32 negedges following a period_start negedge.
    task automatic measure_period();
        ps_at = 0;
        for (int c = 0; c < 4; c++) hi_cnt[c] = 0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (k == 1) first_out = pwm_out;
            for (int c = 0; c < 4; c++) if (pwm_out[c]) hi_cnt[c]++;
            if (period_start && ps_at == 0) ps_at = k;
        end
    endtask

    task automatic test_reset();
        bit   bad;
        int   found;
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests++;
            if ({pwm_out, period_start, duty_ready} !== 6'b0) begin
                fails++;
                $display("[TB] FAIL reset_hold: got %b want 000000", {pwm_out, period_start, duty_ready});
            end
        end
        rst = 1'b0;
        #1;
        tests++;
        if (duty_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL ready_at_release: got %b want 0", duty_ready);
        end
        bad   = 1'b0;
        found = 0;
        for (int k = 1; k <= 40 && found == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                tests++;
                if (duty_ready !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL ready_after_release: got %b want 1", duty_ready);
                end
            end
            if (pwm_out !== 4'b0) bad = 1'b1;
            if (period_start === 1'b1) found = k;
        end
        tests++;
        if (found != 32) begin
            fails++;
            $display("[TB] FAIL first_period_start: got edge %0d want edge 32", found);
        end
        tests++;
        if (bad) begin
            fails++;
            $display("[TB] FAIL idle_pwm: got nonzero pwm_out want 0");
        end
    endtask

    task automatic test_linear();
        send_vec(VEC_LIN, "linear");
        wait_ps("linear_load");
        for (int p = 0; p < 2; p++) begin
            measure_period();
            for (int c = 0; c < 4; c++) begin
                tests++;
                if (hi_cnt[c] != exp_high(VEC_LIN[c*4 +: 4])) begin
                    fails++;
                    $display("[TB] FAIL linear_ch%0d: got %0d high want %0d", c, hi_cnt[c], exp_high(VEC_LIN[c*4 +: 4]));
                end
            end
            tests++;
            if (first_out !== exp_first(VEC_LIN) || ps_at != 32) begin
                fails++;
                $display("[TB] FAIL linear_phase: got first=%b ps_at=%0d want first=%b ps_at=32", first_out, ps_at, exp_first(VEC_LIN));
            end
        end
    endtask

    task automatic test_extremes();
        send_vec(VEC_EXT, "extremes");
        wait_ps("extremes_load");
        for (int p = 0; p < 3; p++) begin
            measure_period();
            for (int c = 0; c < 4; c++) begin
                tests++;
                if (hi_cnt[c] != exp_high(VEC_EXT[c*4 +: 4])) begin
                    fails++;
                    $display("[TB] FAIL extremes_ch%0d: got %0d high want %0d", c, hi_cnt[c], exp_high(VEC_EXT[c*4 +: 4]));
                end
            end
            tests++;
            if (ps_at != 32) begin
                fails++;
                $display("[TB] FAIL extremes_period: got ps_at=%0d want 32", ps_at);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit bad;
        wait_ps("b2b_sync");
        duty_in    = VEC_A;
        duty_valid = 1'b1;
        @(posedge clk);
        #1;
        duty_in = VEC_B;
        bad     = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            if (duty_ready !== 1'b0 || period_start !== 1'b0) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("[TB] FAIL b2b_backpressure: got ready high before boundary want 0");
        end
        @(negedge clk);
        tests++;
        if (duty_ready !== 1'b1 || period_start !== 1'b1) begin
            fails++;
            $display("[TB] FAIL b2b_boundary: got ready=%b ps=%b want 1 1", duty_ready, period_start);
        end
        @(posedge clk);
        #1;
        duty_valid = 1'b0;
        measure_period();
        for (int c = 0; c < 4; c++) begin
            tests++;
            if (hi_cnt[c] != exp_high(VEC_A[c*4 +: 4])) begin
                fails++;
                $display("[TB] FAIL b2b_A_ch%0d: got %0d high want %0d", c, hi_cnt[c], exp_high(VEC_A[c*4 +: 4]));
            end
        end
        measure_period();
        for (int c = 0; c < 4; c++) begin
            tests++;
            if (hi_cnt[c] != exp_high(VEC_B[c*4 +: 4])) begin
                fails++;
                $display("[TB] FAIL b2b_B_ch%0d: got %0d high want %0d", c, hi_cnt[c], exp_high(VEC_B[c*4 +: 4]));
            end
        end
    endtask

    task automatic test_collision();
        wait_ps("coll_sync");
        repeat (31) @(negedge clk);
        duty_in    = VEC_C;
        duty_valid = 1'b1;
        tests++;
        if (duty_ready !== 1'b1 || period_start !== 1'b0) begin
            fails++;
            $display("[TB] FAIL coll_pre: got ready=%b ps=%b want 1 0", duty_ready, period_start);
        end
        @(posedge clk);
        #1;
        duty_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (period_start !== 1'b1 || duty_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL coll_boundary: got ps=%b ready=%b want 1 0", period_start, duty_ready);
        end
        measure_period();
        for (int c = 0; c < 4; c++) begin
            tests++;
            if (hi_cnt[c] != exp_high(VEC_B[c*4 +: 4])) begin
                fails++;
                $display("[TB] FAIL coll_old_ch%0d: got %0d high want %0d", c, hi_cnt[c], exp_high(VEC_B[c*4 +: 4]));
            end
        end
        measure_period();
        for (int c = 0; c < 4; c++) begin
            tests++;
            if (hi_cnt[c] != exp_high(VEC_C[c*4 +: 4])) begin
                fails++;
                $display("[TB] FAIL coll_new_ch%0d: got %0d high want %0d", c, hi_cnt[c], exp_high(VEC_C[c*4 +: 4]));
            end
        end
    endtask

    task automatic test_gamma();
        send_vec(VEC_GAM, "gamma");
        wait_ps("gamma_load");
        measure_period();
        for (int c = 0; c < 4; c++) begin
            tests++;
            if (hi_cnt[c] != exp_high(VEC_GAM[c*4 +: 4])) begin
                fails++;
                $display("[TB] FAIL gamma_ch%0d: got %0d high want %0d", c, hi_cnt[c], exp_high(VEC_GAM[c*4 +: 4]));
            end
        end
    endtask

    task automatic test_mid_reset();
        bit bad;
        send_vec(VEC_MID, "mid");
        wait_ps("mid_load");
        duty_in    = VEC_PEND;
        duty_valid = 1'b1;
        @(posedge clk);
        #1;
        duty_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (pwm_out[0] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL mid_pre: got pwm0=%b want 1", pwm_out[0]);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({pwm_out, period_start, duty_ready} !== 6'b0) begin
            fails++;
            $display("[TB] FAIL mid_async: got %b want 000000", {pwm_out, period_start, duty_ready});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 1) begin
                tests++;
                if (duty_ready !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL mid_ready: got %b want 1", duty_ready);
                end
            end
            if (pwm_out !== 4'b0) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("[TB] FAIL mid_discard: got nonzero pwm_out after reset want 0");
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        duty_in    = '0;
        duty_valid = 1'b0;
        test_reset();
        test_linear();
        test_extremes();
        test_back_to_back();
        test_collision();
        test_gamma();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
